// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction handshake plus ALU operand/result bus.
//   Instr/InstrValid/InstrReady : fetch -> controller valid/ready handshake
//   A/B/ALUSelect               : controller -> ALU operands and select
//   Result/C/Z                  : ALU -> controller outcome
// master = fetch/ALU side, slave = issue controller.
interface alu_issue_ctrl_if;
  logic [15:0] Instr;
  logic        InstrValid;
  logic        InstrReady;
  logic [7:0]  A;
  logic [7:0]  B;
  logic [2:0]  ALUSelect;
  logic [7:0]  Result;
  logic        C;
  logic        Z;

  modport master (
    output Instr, InstrValid, Result, C, Z,
    input  InstrReady, A, B, ALUSelect
  );

  modport slave (
    input  Instr, InstrValid, Result, C, Z,
    output InstrReady, A, B, ALUSelect
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one instruction at a time through the 8-bit ALU.
// IDLE (accept, load operands) -> EXEC (capture ALU outcome) -> WB (commit).
// Ports:
//   Clk, Reset_n        : clock, async active-low reset
//   bus (slave)         : instruction handshake and ALU operand/result bus
//   Done, BranchTaken   : one-cycle retire / taken-branch pulses
//   BranchTarget        : branch target (imm), valid with BranchTaken
//   FlagC, FlagZ        : stored flags
//   DbgAddr, DbgData    : combinational register-file debug read
//   Trap                : sticky illegal-opcode flag
// Optional feature macro: ILLEGAL_TRAP_EN (illegal op halts and sets Trap;
// otherwise illegal ops retire as NOPs and Trap is tied 0).
module alu_issue_ctrl #(
  parameter int       NREGS       = 4,
  parameter bit [2:0] ILLEGAL_SEL = 3'b111
) (
  input  logic             Clk,
  input  logic             Reset_n,
  alu_issue_ctrl_if.slave  bus,
  output logic             Done,
  output logic             BranchTaken,
  output logic [7:0]       BranchTarget,
  output logic             FlagC,
  output logic             FlagZ,
  input  logic [1:0]       DbgAddr,
  output logic [7:0]       DbgData,
  output logic             Trap
);

  typedef enum logic [1:0] {IDLE, EXEC, WB, HALT} state_t;

  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2,
                         OP_OR  = 4'd3, OP_ADDNF = 4'd4, OP_LDI = 4'd5,
                         OP_MOV = 4'd6, OP_CMP = 4'd7, OP_BZ = 4'd8,
                         OP_BC  = 4'd9;

  state_t                     state_q, state_d;
  logic [15:0]                ir_q, ir_d;
  logic [NREGS-1:0][7:0]      rf_q, rf_d;
  logic [7:0]                 a_q, a_d, b_q, b_d;
  logic [2:0]                 sel_q, sel_d;
  logic [7:0]                 res_q, res_d;
  logic                       cs_q, cs_d, zs_q, zs_d;
  logic                       fc_q, fc_d, fz_q, fz_d;
  logic                       rdy_q, rdy_d;
  logic                       done_q, done_d;
  logic                       bt_q, bt_d;
  logic [7:0]                 tgt_q, tgt_d;
  logic                       trap_q, trap_d;

  logic [3:0] op;
  logic [1:0] rd, rs, in_rd, in_rs;
  logic [7:0] imm;
  logic [2:0] in_sel;

  assign op    = ir_q[15:12];
  assign rd    = ir_q[11:10];
  assign rs    = ir_q[9:8];
  assign imm   = ir_q[7:0];
  assign in_rd = bus.Instr[11:10];
  assign in_rs = bus.Instr[9:8];

  // ALU select for the incoming opcode; non-ALU and illegal ops keep it idle.
  always_comb begin
    case (bus.Instr[15:12])
      OP_ADD:   in_sel = 3'b000;
      OP_SUB:   in_sel = 3'b001;
      OP_AND:   in_sel = 3'b010;
      OP_OR:    in_sel = 3'b100;
      OP_ADDNF: in_sel = 3'b110;
      OP_CMP:   in_sel = 3'b001;
      default:  in_sel = ILLEGAL_SEL;
    endcase
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    rf_d    = rf_q;
    a_d     = a_q;
    b_d     = b_q;
    sel_d   = sel_q;
    res_d   = res_q;
    cs_d    = cs_q;
    zs_d    = zs_q;
    fc_d    = fc_q;
    fz_d    = fz_q;
    rdy_d   = rdy_q;
    done_d  = 1'b0;
    bt_d    = 1'b0;
    tgt_d   = tgt_q;
    trap_d  = trap_q;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (bus.InstrValid && rdy_q) begin
          ir_d    = bus.Instr;
          a_d     = rf_q[in_rd];
          b_d     = rf_q[in_rs];
          sel_d   = in_sel;
          rdy_d   = 1'b0;
          state_d = EXEC;
        end
      end
      EXEC: begin
        res_d = bus.Result;
        cs_d  = bus.C;
        // ADDNF's Z output is don't-care; leave the stage untouched.
        if (op != OP_ADDNF) zs_d = bus.Z;
        state_d = WB;
      end
      WB: begin
        sel_d   = ILLEGAL_SEL;
        state_d = IDLE;
        rdy_d   = 1'b1;
        done_d  = 1'b1;
        case (op)
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            rf_d[rd] = res_q;
            fc_d     = cs_q;
            fz_d     = zs_q;
          end
          OP_ADDNF: begin
            rf_d[rd] = res_q;
            fc_d     = cs_q;
          end
          OP_LDI: rf_d[rd] = imm;
          // b_q still holds R[rs] sampled at accept; nothing else is in flight.
          OP_MOV: rf_d[rd] = b_q;
          OP_CMP: begin
            fc_d = cs_q;
            fz_d = zs_q;
          end
          OP_BZ: begin
            bt_d  = fz_q;
            tgt_d = imm;
          end
          OP_BC: begin
            bt_d  = fc_q;
            tgt_d = imm;
          end
          default: begin
`ifdef ILLEGAL_TRAP_EN
            trap_d  = 1'b1;
            done_d  = 1'b0;
            rdy_d   = 1'b0;
            state_d = HALT;
`endif
          end
        endcase
      end
      HALT: begin
        rdy_d = 1'b0;
        sel_d = ILLEGAL_SEL;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      ir_q    <= '0;
      rf_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sel_q   <= ILLEGAL_SEL;
      res_q   <= '0;
      cs_q    <= 1'b0;
      zs_q    <= 1'b0;
      fc_q    <= 1'b0;
      fz_q    <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      bt_q    <= 1'b0;
      tgt_q   <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      rf_q    <= rf_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sel_q   <= sel_d;
      res_q   <= res_d;
      cs_q    <= cs_d;
      zs_q    <= zs_d;
      fc_q    <= fc_d;
      fz_q    <= fz_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      bt_q    <= bt_d;
      tgt_q   <= tgt_d;
      trap_q  <= trap_d;
    end
  end

  assign bus.InstrReady = rdy_q;
  assign bus.A          = a_q;
  assign bus.B          = b_q;
  assign bus.ALUSelect  = sel_q;
  assign Done           = done_q;
  assign BranchTaken    = bt_q;
  assign BranchTarget   = tgt_q;
  assign FlagC          = fc_q;
  assign FlagZ          = fz_q;
  assign DbgData        = rf_q[DbgAddr];
`ifdef ILLEGAL_TRAP_EN
  assign Trap           = trap_q;
`else
  assign Trap           = 1'b0;
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: randomized + directed bench with a behavioural ALU and
// an instruction-level architectural model (registers, flags, branch result).
module tb_alu_issue_ctrl;
  logic       Clk = 1'b0;
  logic       Reset_n = 1'b1;
  logic       Done, BranchTaken, FlagC, FlagZ, Trap;
  logic [7:0] BranchTarget, DbgData;
  logic [1:0] DbgAddr = 2'd0;
  int         n_chk = 0, n_fail = 0;

  alu_issue_ctrl_if bus();

  alu_issue_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .bus(bus), .Done(Done),
    .BranchTaken(BranchTaken), .BranchTarget(BranchTarget),
    .FlagC(FlagC), .FlagZ(FlagZ), .DbgAddr(DbgAddr), .DbgData(DbgData),
    .Trap(Trap)
  );

  always #5 Clk = ~Clk;

  // Stand-in ALU. Z for select 110 is noise so any use of it shows up.
  logic [7:0] alu_r;
  logic       alu_c, alu_z, znoise = 1'b0;
  always @(negedge Clk) znoise <= 1'($urandom);
  always_comb begin
    alu_r = 8'h00; alu_c = 1'b0; alu_z = 1'b0;
    case (bus.ALUSelect)
      3'b000: begin {alu_c, alu_r} = {1'b0, bus.A} + {1'b0, bus.B}; alu_z = (alu_r == 8'h00); end
      3'b001: begin alu_r = bus.A - bus.B; alu_c = bus.A < bus.B; alu_z = (alu_r == 8'h00); end
      3'b010: begin alu_r = bus.A & bus.B; alu_z = (alu_r == 8'h00); end
      3'b100: begin alu_r = bus.A | bus.B; alu_z = (alu_r == 8'h00); end
      3'b110: begin {alu_c, alu_r} = {1'b0, bus.A} + {1'b0, bus.B}; alu_z = znoise; end
      default: ;
    endcase
  end
  assign bus.Result = alu_r;
  assign bus.C      = alu_c;
  assign bus.Z      = alu_z;

  initial begin
    bus.Instr = 16'h0000;
    bus.InstrValid = 1'b0;
  end

  // Architectural model
  logic [7:0] m_r [4];
  logic       m_c, m_z, m_trap;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int imm);
    return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_r[i] = 8'h00;
    m_c = 1'b0; m_z = 1'b0; m_trap = 1'b0;
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < 4; i++) begin
      DbgAddr = 2'(i); #1;
      chk(tag, DbgData, m_r[i]);
    end
  endtask

  // Applies one instruction and its spec semantics to the model.
  task automatic model_step(input logic [15:0] ins, output logic e_done,
                            output logic e_bt, output logic [7:0] e_tgt);
    int op; logic [1:0] rd, rs; logic [7:0] imm, a, b; logic [8:0] s;
    op = int'(ins[15:12]); rd = ins[11:10]; rs = ins[9:8]; imm = ins[7:0];
    a = m_r[rd]; b = m_r[rs];
    e_done = 1'b1; e_bt = 1'b0; e_tgt = imm;
    case (op)
      0: begin s = a + b; m_r[rd] = s[7:0]; m_c = s[8]; m_z = (s[7:0] == 0); end
      1: begin m_r[rd] = a - b; m_c = (a < b); m_z = (a == b); end
      2: begin m_r[rd] = a & b; m_c = 1'b0; m_z = ((a & b) == 0); end
      3: begin m_r[rd] = a | b; m_c = 1'b0; m_z = ((a | b) == 0); end
      4: begin s = a + b; m_r[rd] = s[7:0]; m_c = s[8]; end
      5: m_r[rd] = imm;
      6: m_r[rd] = b;
      7: begin m_c = (a < b); m_z = (a == b); end
      8: e_bt = m_z;
      9: e_bt = m_c;
      default: begin
`ifdef ILLEGAL_TRAP_EN
        e_done = 1'b0; m_trap = 1'b1;
`endif
      end
    endcase
  endtask

  function automatic logic [2:0] exp_sel(input logic [3:0] op);
    case (op)
      4'd0: return 3'b000;
      4'd1: return 3'b001;
      4'd2: return 3'b010;
      4'd3: return 3'b100;
      4'd4: return 3'b110;
      4'd7: return 3'b001;
      default: return 3'b111;
    endcase
  endfunction

  // Enters and leaves at a falling edge.
  task automatic do_instr(input logic [15:0] ins);
    int n; logic e_done, e_bt; logic [7:0] e_tgt, ea, eb;
    n = 0;
    while (!bus.InstrReady && n < 20) begin @(negedge Clk); n++; end
    if (n == 20) chk("ready_timeout", 0, 1);
    ea = m_r[ins[11:10]]; eb = m_r[ins[9:8]];
    bus.Instr = ins; bus.InstrValid = 1'b1;
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    chk("exec_rdy", bus.InstrReady, 0);
    chk("exec_done", Done, 0);
    chk("exec_a", bus.A, ea);
    chk("exec_b", bus.B, eb);
    chk("exec_sel", bus.ALUSelect, exp_sel(ins[15:12]));
    @(posedge Clk); #1;
    chk("wb_done", Done, 0);
    @(posedge Clk); #1;
    model_step(ins, e_done, e_bt, e_tgt);
    chk("ret_done", Done, e_done);
    chk("ret_bt", BranchTaken, e_bt);
    if (e_bt) chk("ret_tgt", BranchTarget, e_tgt);
    chk("ret_fc", FlagC, m_c);
    chk("ret_fz", FlagZ, m_z);
    chk("ret_sel", bus.ALUSelect, 3'b111);
    chk("ret_trap", Trap, m_trap);
    check_regs("ret_reg");
  endtask

  initial begin
    int acc, dn, op;
    model_reset();
    #2 Reset_n = 1'b0;
    #1;
    chk("rst_rdy", bus.InstrReady, 0);
    chk("rst_sel", bus.ALUSelect, 3'b111);
    chk("rst_a", bus.A, 0);
    chk("rst_b", bus.B, 0);
    chk("rst_fc", FlagC, 0);
    chk("rst_fz", FlagZ, 0);
    chk("rst_done", Done, 0);
    chk("rst_bt", BranchTaken, 0);
    chk("rst_tgt", BranchTarget, 0);
    chk("rst_trap", Trap, 0);
    check_regs("rst_reg");
    repeat (2) @(posedge Clk);
    @(negedge Clk); Reset_n = 1'b1;
    #1 chk("rel_rdy0", bus.InstrReady, 0);
    @(posedge Clk); #1;
    chk("rel_rdy1", bus.InstrReady, 1);
    #4;

    // Wrap-around ADD
    do_instr(mk(5, 1, 0, 8'hFF));
    do_instr(mk(5, 2, 0, 8'h01));
    do_instr(mk(0, 1, 2, 0));
    // SUB with borrow, then CMP equal
    do_instr(mk(5, 0, 0, 3));
    do_instr(mk(5, 3, 0, 5));
    do_instr(mk(1, 0, 3, 0));
    do_instr(mk(7, 3, 3, 0));
    // ADDNF keeps Z, then taken BZ
    do_instr(mk(4, 1, 2, 0));
    do_instr(mk(8, 0, 0, 8'h40));
    do_instr(mk(9, 0, 0, 8'h22));
    do_instr(mk(6, 2, 0, 0));

    // Valid held high: one accept every 3 cycles
    acc = 0; dn = 0;
    bus.Instr = mk(5, 2, 0, 8'h5A); bus.InstrValid = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (bus.InstrReady) acc++;
      @(posedge Clk); #1;
      if (Done) dn++;
      #4;
    end
    bus.InstrValid = 1'b0;
    m_r[2] = 8'h5A;
    chk("hold_accepts", acc, 4);
    chk("hold_dones", dn, 4);
    check_regs("hold_reg");

    // Random program
    for (int k = 0; k < 150; k++) begin
      op = $urandom_range(0, 10);
`ifdef ILLEGAL_TRAP_EN
      if (op == 10) op = 5;
`else
      if (op == 10) op = $urandom_range(10, 15);
`endif
      do_instr(mk(op, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 255)));
    end

    // Reset during EXEC aborts the instruction
    do_instr(mk(5, 0, 0, 8'h77));
    while (!bus.InstrReady) @(negedge Clk);
    bus.Instr = mk(0, 0, 0, 0); bus.InstrValid = 1'b1;
    @(posedge Clk); #1;
    bus.InstrValid = 1'b0;
    Reset_n = 1'b0; #1;
    model_reset();
    chk("mid_done", Done, 0);
    chk("mid_rdy", bus.InstrReady, 0);
    chk("mid_sel", bus.ALUSelect, 3'b111);
    chk("mid_fc", FlagC, 0);
    check_regs("mid_reg");
    @(posedge Clk); #1;
    chk("mid_done2", Done, 0);
    @(negedge Clk); Reset_n = 1'b1;
    @(posedge Clk); #1;
    chk("mid_rdy1", bus.InstrReady, 1);
    chk("mid_done3", Done, 0);
    #4;
    do_instr(mk(5, 3, 0, 8'h11));
    do_instr(mk(7, 3, 0, 0));

    // Illegal opcode
    do_instr(mk(12, 1, 2, 0));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      chk("halt_rdy", bus.InstrReady, 0);
      chk("halt_done", Done, 0);
      chk("halt_trap", Trap, 1);
      chk("halt_sel", bus.ALUSelect, 3'b111);
    end
`else
    do_instr(mk(5, 1, 0, 8'hA5));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end
endmodule
